// File: rtl/sine_voice_bank.sv
// rtl/sine_voice_bank.sv - multi-voice quarter-wave sine synthesiser with a time-multiplexed mixer
// Build option: define SINE_VOICE_BANK_SAT_EN to clamp the full-width sum instead of scaling it down.
module sine_voice_bank #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 32,
  parameter int ADDR_W     = 10,
  parameter int OUT_W      = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_voice,
  input  logic [PHASE_W-1:0] cfg_phase_inc,
  input  logic [6:0]         cfg_volume,
  input  logic               cfg_gate,
  output logic [OUT_W-1:0]   mix_out,
  output logic               mix_valid,
  output logic               busy,
  output logic               tick_overrun
);
  localparam int ROM_D = 1 << ADDR_W;
  localparam int ACC_W = OUT_W + 4;
  localparam logic [3:0] LAST_V = 4'(NUM_VOICES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_MAC   = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]         r_state;
  logic [3:0]         r_voice;
  logic [PHASE_W-1:0] r_sh_inc  [NUM_VOICES];
  logic [PHASE_W-1:0] r_act_inc [NUM_VOICES];
  logic [PHASE_W-1:0] r_phase   [NUM_VOICES];
  logic [6:0]         r_sh_vol  [NUM_VOICES];
  logic [6:0]         r_act_vol [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_sh_gate;
  logic [NUM_VOICES-1:0] r_act_gate;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_neg;
  logic [OUT_W-1:0]   r_rom_q;
  logic [ACC_W-1:0]   r_acc;
  logic [OUT_W-1:0]   r_mix_out;
  logic               r_mix_valid;
  logic               r_busy;
  logic               r_overrun;

  function automatic logic [OUT_W-1:0] rom_value(input int i);
    real amp;
    real ang;
    amp = (2.0 ** (OUT_W - 1)) - 1.0;
    ang = 3.14159265358979323846 * i / (2.0 ** (ADDR_W + 1));
    return OUT_W'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [OUT_W-1:0] w_rom [ROM_D];
  for (genvar g = 0; g < ROM_D; g++) begin : g_rom
    assign w_rom[g] = rom_value(g);
  end

  logic [ADDR_W+1:0] w_top;
  logic [6:0]        w_vol;
  logic              w_gate;
  always_comb begin
    w_top  = '0;
    w_vol  = '0;
    w_gate = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (r_voice == 4'(v)) begin
        w_top  = r_phase[v][PHASE_W-1 -: ADDR_W+2];
        w_vol  = r_act_vol[v];
        w_gate = r_act_gate[v];
      end
    end
  end

  // Odd quadrants read the table backwards: 2^ADDR_W-1-idx is the bitwise inverse of idx.
  logic [ADDR_W-1:0] w_addr;
  assign w_addr = w_top[ADDR_W] ? ~w_top[ADDR_W-1:0] : w_top[ADDR_W-1:0];

  // Scale the magnitude first and apply the sign afterwards so both half-waves are symmetric.
  logic [OUT_W+6:0] w_prod;
  logic [OUT_W-1:0] w_mag;
  logic [ACC_W-1:0] w_contrib;
  assign w_prod    = {7'd0, r_rom_q} * {{OUT_W{1'b0}}, w_vol};
  assign w_mag     = OUT_W'(w_prod >> 7);
  assign w_contrib = !w_gate ? '0 : (r_neg ? -{4'd0, w_mag} : {4'd0, w_mag});

  logic [OUT_W-1:0] w_mix;
`ifdef SINE_VOICE_BANK_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {5'b00000, {(OUT_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {5'b11111, {(OUT_W-1){1'b0}}};
  always_comb begin
    if ($signed(r_acc) > $signed(SAT_MAX))
      w_mix = OUT_W'(SAT_MAX);
    else if ($signed(r_acc) < $signed(SAT_MIN))
      w_mix = OUT_W'(SAT_MIN);
    else
      w_mix = r_acc[OUT_W-1:0];
  end
`else
  localparam int SHIFT = $clog2(NUM_VOICES);
  assign w_mix = OUT_W'($signed(r_acc) >>> SHIFT);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_rom_q <= '0;
    else
      r_rom_q <= w_rom[r_rom_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_voice     <= '0;
      r_sh_gate   <= '0;
      r_act_gate  <= '0;
      r_rom_addr  <= '0;
      r_neg       <= 1'b0;
      r_acc       <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_sh_inc[v]  <= '0;
        r_act_inc[v] <= '0;
        r_phase[v]   <= '0;
        r_sh_vol[v]  <= '0;
        r_act_vol[v] <= '0;
      end
    end else begin
      r_mix_valid <= 1'b0;
      r_overrun   <= sample_tick && (r_state != S_IDLE);
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (cfg_we && cfg_voice == 4'(v)) begin
          r_sh_inc[v]  <= cfg_phase_inc;
          r_sh_vol[v]  <= cfg_volume;
          r_sh_gate[v] <= cfg_gate;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (sample_tick) begin
            r_state    <= S_FETCH;
            r_busy     <= 1'b1;
            r_voice    <= '0;
            r_acc      <= '0;
            r_act_gate <= r_sh_gate;
            for (int v = 0; v < NUM_VOICES; v++) begin
              r_act_inc[v] <= r_sh_inc[v];
              r_act_vol[v] <= r_sh_vol[v];
              if (r_sh_gate[v] && !r_act_gate[v])
                r_phase[v] <= '0;
            end
          end
        end
        S_FETCH: begin
          r_rom_addr <= w_addr;
          r_neg      <= w_top[ADDR_W+1];
          r_state    <= S_WAIT;
        end
        S_WAIT: r_state <= S_MAC;
        S_MAC: begin
          r_acc <= r_acc + w_contrib;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_voice == 4'(v) && r_act_gate[v])
              r_phase[v] <= r_phase[v] + r_act_inc[v];
          end
          if (r_voice == LAST_V) begin
            r_state <= S_OUT;
          end else begin
            r_voice <= r_voice + 4'd1;
            r_state <= S_FETCH;
          end
        end
        S_OUT: begin
          r_mix_out   <= w_mix;
          r_mix_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mix_out      = r_mix_out;
  assign mix_valid    = r_mix_valid;
  assign busy         = r_busy;
  assign tick_overrun = r_overrun;
endmodule
